// File: rtl/logic_gate_pkg.sv
// Shared types and the bitwise reduction used by logic_gate_pipe.
package logic_gate_pkg;

    localparam int unsigned OP_W   = 3;
    // Upper bounds for the generic reduction; instances zero-extend into these.
    localparam int unsigned MAX_W  = 64;
    localparam int unsigned MAX_IN = 16;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_PASS = 3'd6,
        OP_ZERO = 3'd7
    } op_e;

    // Operand k lives at [k*MAX_W +: MAX_W]; only the first num_in operands take part.
    function automatic logic [MAX_W-1:0] reduce_op(
        input op_e                       op,
        input logic [MAX_IN*MAX_W-1:0]   operands,
        input int unsigned               num_in
    );
        logic [MAX_W-1:0] and_r;
        logic [MAX_W-1:0] or_r;
        logic [MAX_W-1:0] xor_r;
        logic [MAX_W-1:0] res;
        and_r = '1;
        or_r  = '0;
        xor_r = '0;
        for (int unsigned k = 0; k < MAX_IN; k++) begin
            if (k < num_in) begin
                and_r &= operands[k*MAX_W +: MAX_W];
                or_r  |= operands[k*MAX_W +: MAX_W];
                xor_r ^= operands[k*MAX_W +: MAX_W];
            end
        end
        case (op)
            OP_AND:  res = and_r;
            OP_OR:   res = or_r;
            OP_XOR:  res = xor_r;
            OP_NAND: res = ~and_r;
            OP_NOR:  res = ~or_r;
            OP_XNOR: res = ~xor_r;
            OP_PASS: res = operands[MAX_W-1:0];
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/logic_gate_stage.sv
// One valid/ready register slice: loads when empty or draining this cycle.
module logic_gate_stage
#(
    parameter int unsigned PW = 2
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [PW-1:0] in_data,
    input  logic          down_ready,
    output logic          ready_c,
    output logic          valid,
    output logic [PW-1:0] data
);

    logic move_c;
    logic load_c;

    assign move_c  = valid && down_ready;
    assign ready_c = !valid || move_c;
    assign load_c  = in_valid && ready_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load_c) begin
            valid <= 1'b1;
            data  <= in_data;
        end else if (move_c) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/logic_gate_pipe.sv
// Pipelined NUM_IN-operand bitwise logic unit with valid/ready flow control.
// Optional result statistics enabled by defining LOGIC_GATE_PIPE_STATS_EN.
module logic_gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned NUM_IN = 2,
    parameter int unsigned STAGES = 1,
    parameter int unsigned CNT_W  = 16
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [OP_W-1:0]         op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_all_ones
`ifdef LOGIC_GATE_PIPE_STATS_EN
    ,
    input  logic                    stats_clr,
    output logic [CNT_W-1:0]        hit_cnt,
    output logic [CNT_W-1:0]        miss_cnt
`endif
);

    localparam int unsigned PW = WIDTH + 1;

    logic [MAX_IN*MAX_W-1:0] opnds_ext;
    logic [WIDTH-1:0]        result_c;
    logic [STAGES-1:0]       v;
    logic [PW-1:0]           d [STAGES];

    always_comb begin
        opnds_ext = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            opnds_ext[k*MAX_W +: WIDTH] = in_data[k*WIDTH +: WIDTH];
        end
    end

    assign result_c = WIDTH'(reduce_op(op_e'(op), opnds_ext, NUM_IN));

    // Payload layout per stage: {all_ones, result}.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic          rdy;
        logic          up_v;
        logic [PW-1:0] up_d;
        logic          dn_r;

        if (i == 0) begin : g_head
            assign up_v = in_valid;
            assign up_d = {&result_c, result_c};
        end else begin : g_body
            assign up_v = v[i-1];
            assign up_d = d[i-1];
        end

        if (i == STAGES - 1) begin : g_tail
            assign dn_r = out_ready;
        end else begin : g_link
            assign dn_r = g_stage[i+1].rdy;
        end

        logic_gate_stage #(.PW(PW)) u_stage (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (up_v),
            .in_data    (up_d),
            .down_ready (dn_r),
            .ready_c    (rdy),
            .valid      (v[i]),
            .data       (d[i])
        );
    end

    assign in_ready     = g_stage[0].rdy;
    assign out_valid    = v[STAGES-1];
    assign out_data     = d[STAGES-1][WIDTH-1:0];
    assign out_all_ones = d[STAGES-1][WIDTH];

`ifdef LOGIC_GATE_PIPE_STATS_EN
    // Saturating hit/miss counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (stats_clr) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (out_valid && out_ready) begin
            if (out_all_ones) begin
                if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
            end else begin
                if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Scoreboard bench for logic_gate_pipe (WIDTH=4, NUM_IN=3, STAGES=3, CNT_W=2).
module tb_logic_gate_pipe;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned NUM_IN = 3;
    localparam int unsigned STAGES = 3;
    localparam int unsigned CNT_W  = 2;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             ao;
        int               acc;
        bit               lat;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [NUM_IN*WIDTH-1:0] in_data = '0;
    logic [2:0]              op = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [WIDTH-1:0]        out_data;
    logic                    out_all_ones;
`ifdef LOGIC_GATE_PIPE_STATS_EN
    logic                    stats_clr = 1'b0;
    logic [CNT_W-1:0]        hit_cnt;
    logic [CNT_W-1:0]        miss_cnt;
`endif

    logic_gate_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .op           (op),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_all_ones (out_all_ones)
`ifdef LOGIC_GATE_PIPE_STATS_EN
        ,
        .stats_clr    (stats_clr),
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    exp_t exp_q[$];
    int   m_hit = 0;
    int   m_miss = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: per bit, count ones across operands and apply the op's rule.
    function automatic logic [WIDTH-1:0] ref_op(input int o, input logic [NUM_IN*WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        for (int b = 0; b < WIDTH; b++) begin
            int cnt = 0;
            for (int k = 0; k < NUM_IN; k++) cnt += int'(x[k*WIDTH + b]);
            case (o)
                0: r[b] = (cnt == NUM_IN);
                1: r[b] = (cnt > 0);
                2: r[b] = (cnt % 2 == 1);
                3: r[b] = (cnt != NUM_IN);
                4: r[b] = (cnt == 0);
                5: r[b] = (cnt % 2 == 0);
                6: r[b] = x[b];
                default: r[b] = 1'b0;
            endcase
        end
        return r;
    endfunction

    function automatic void push_exp(input logic [WIDTH-1:0] e, input bit lat);
        exp_q.push_back('{d: e, ao: &e, acc: cyc + 1, lat: lat});
    endfunction

    // Monitor: samples just before each rising edge, pops on every output handshake.
    always begin
        @(negedge clk);
        #4;
        if (rst) begin
            m_hit  = 0;
            m_miss = 0;
        end else begin
`ifdef LOGIC_GATE_PIPE_STATS_EN
            check("hit_cnt", 32'(hit_cnt), 32'(m_hit));
            check("miss_cnt", 32'(miss_cnt), 32'(m_miss));
`endif
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got %0h, required no handshake (cycle %0d)", out_data, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(e.d));
                    check("out_all_ones", 32'(out_all_ones), 32'(e.ao));
                    if (e.lat) check("latency", 32'(cyc + 1 - e.acc), STAGES);
                end
            end
`ifdef LOGIC_GATE_PIPE_STATS_EN
            if (stats_clr) begin
                m_hit  = 0;
                m_miss = 0;
            end else if (out_valid && out_ready) begin
                if (out_all_ones) begin
                    if (m_hit < (1 << CNT_W) - 1) m_hit++;
                end else begin
                    if (m_miss < (1 << CNT_W) - 1) m_miss++;
                end
            end
`endif
        end
    end

    // Drive one operand set (call at a falling edge); returns at the next falling edge.
    task automatic send_exp(input logic [2:0] o, input logic [NUM_IN*WIDTH-1:0] x,
                            input logic [WIDTH-1:0] e, input bit lat);
        int n = 0;
        in_valid = 1'b1;
        op       = o;
        in_data  = x;
        forever begin
            #4;
            if (in_ready) begin
                push_exp(e, lat);
                break;
            end
            @(negedge clk);
            n++;
            if (n > 200) begin
                check("accept_timeout", 32'(n), 32'(0));
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [2:0] o, input logic [NUM_IN*WIDTH-1:0] x, input bit lat);
        send_exp(o, x, ref_op(int'(o), x), lat);
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'(0));
    endtask

    logic [WIDTH-1:0]        dir_exp [8];
    logic [NUM_IN*WIDTH-1:0] x;
    logic [2:0]              o;
    logic [WIDTH-1:0]        held;
    int                      acc;
    bit                      pend;

    initial begin
        dir_exp = '{4'h2, 4'hF, 4'h3, 4'hD, 4'h0, 4'hC, 4'hF, 4'h0};

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_all_ones", 32'(out_all_ones), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'(1));
`ifdef LOGIC_GATE_PIPE_STATS_EN
        check("rst_hit", 32'(hit_cnt), 32'(0));
        check("rst_miss", 32'(miss_cnt), 32'(0));
`endif
        @(negedge clk);

        // All eight ops on operands F/A/6, free flow
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_exp(3'(i), {4'h6, 4'hA, 4'hF}, dir_exp[i], 1'b1);
        drain();

        // Back-to-back random stream, latency checked on every result
        for (int i = 0; i < 12; i++) send(3'($urandom_range(0, 7)), (NUM_IN*WIDTH)'($urandom), 1'b1);
        drain();

        // Stall: consumer blocked while producer keeps offering
        out_ready = 1'b0;
        acc  = 0;
        held = '0;
        x    = (NUM_IN*WIDTH)'($urandom);
        o    = 3'($urandom_range(0, 7));
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = x;
            op       = o;
            #4;
            if (in_ready) begin
                push_exp(ref_op(int'(o), x), 1'b0);
                acc++;
                x = (NUM_IN*WIDTH)'($urandom);
                o = 3'($urandom_range(0, 7));
            end
            if (i == 3) held = out_data;
            @(negedge clk);
        end
        check("stall_accepts", 32'(acc), 32'(STAGES));
        check("stall_in_ready", 32'(in_ready), 32'(0));
        check("stall_out_valid", 32'(out_valid), 32'(1));
        check("stall_out_stable", 32'(out_data), 32'(held));
        in_valid = 1'b0;
        drain();

        // Random traffic with random backpressure
        pend = 1'b0;
        for (int i = 0; i < 300; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!pend) in_valid = 1'b0;
            if (!pend && $urandom_range(0, 2) != 0) begin
                in_valid = 1'b1;
                in_data  = (NUM_IN*WIDTH)'($urandom);
                op       = 3'($urandom_range(0, 7));
                pend     = 1'b1;
            end
            #4;
            if (in_valid && in_ready) begin
                push_exp(ref_op(int'(op), in_data), 1'b0);
                pend = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        drain();

        // Reset with two results in flight
        out_ready = 1'b0;
        send(3'd1, {4'h0, 4'h0, 4'h9}, 1'b0);
        send(3'd6, {4'h0, 4'h0, 4'hF}, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_out_data", 32'(out_data), 32'(0));
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'(1));
        repeat (8) @(negedge clk);
        check("midrst_no_output", 32'(out_valid), 32'(0));

`ifdef LOGIC_GATE_PIPE_STATS_EN
        // Saturation: five hits, one miss on a 2-bit counter
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        for (int i = 0; i < 5; i++) send(3'd1, '1, 1'b0);
        send(3'd7, '1, 1'b0);
        drain();
        @(negedge clk);
        check("sat_hit", 32'(hit_cnt), 32'(3));
        check("sat_miss", 32'(miss_cnt), 32'(1));

        // Clear coinciding with an output handshake
        out_ready = 1'b0;
        send(3'd7, '0, 1'b0);
        repeat (STAGES) @(negedge clk);
        stats_clr = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        check("clr_hit", 32'(hit_cnt), 32'(0));
        check("clr_miss", 32'(miss_cnt), 32'(0));
        drain();
`endif

        repeat (3) @(negedge clk);
        check("final_queue", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
